sram_fill_sched: RTL

- Background SRAM block-fill sequencer for the card's 1 MB SRAM.
- Writes a constant or incrementing byte pattern over a programmed address range.
- Uses only bus-free windows that the host slot logic announces, so 6502 register/RAM accesses at S4..S7 are never disturbed.
- Sits beside the slot address/data logic; its FA/FD/FCS/FWE outputs are muxed onto the SRAM pins whenever Owner=1.

---
 rtl/sram_fill_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sram_fill_sched.sv
// sram_fill_sched: background block-fill sequencer for the card's 1 MB SRAM.
//
// The engine writes a constant or incrementing byte pattern over a programmed
// address range. It touches the SRAM only inside bus-free windows that the
// slot logic announces with WinOK. Every byte takes a SETUP / STROBE / HOLD
// triple, so the 6502 register and RAM accesses are never disturbed.
//
// Ports:
//   C7M        7 MHz system clock; all logic on its rising edge
//   RES        asynchronous active-high reset
//   WinOK      one-cycle pulse; a free window of >= 4 cycles starts next cycle
//   HostOwn    level; the slot logic currently owns the SRAM
//   Start      one-cycle pulse; latch parameters and begin a transfer
//   Abort      one-cycle pulse; stop the transfer early
//   StartAddr  first SRAM address
//   Len        number of bytes to write (0 = finish immediately)
//   FillData   pattern seed byte
//   Pattern    0 = constant FillData, 1 = FillData + byte index
//   Busy       transfer in progress
//   Done       one-cycle pulse when a transfer ends
//   Owner      engine drives the SRAM pins (muxed in by the slot logic)
//   FA/FD      SRAM address / write data, held between writes
//   FCS/FWE    SRAM chip select / write strobe, active-high
//   Remain     bytes still to write

module sram_fill_sched #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 16
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              WinOK,
  input  logic              HostOwn,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [LEN_W-1:0]  Len,
  input  logic [7:0]        FillData,
  input  logic              Pattern,
  output logic              Busy,
  output logic              Done,
  output logic              Owner,
  output logic [ADDR_W-1:0] FA,
  output logic [7:0]        FD,
  output logic              FCS,
  output logic              FWE,
  output logic [LEN_W-1:0]  Remain
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_FIN
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  byte_idx;
  logic [7:0]        fill_q;
  logic              pattern_q;
  logic              abort_pend;
  logic [7:0]        byte_val;
  logic              last_byte;

  assign byte_val  = pattern_q ? (fill_q + byte_idx[7:0]) : fill_q;
  assign last_byte = (Remain == LEN_W'(1));

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort takes priority over WinOK in WAIT and over HostOwn in SETUP:
  // in both cases no strobe has been issued, so the byte is simply dropped.
  // Once STROBE has started the byte always runs through HOLD.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          next_state = (Len == '0) ? S_FIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (Abort) begin
          next_state = S_FIN;
        end else if (WinOK && !HostOwn) begin
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (Abort) begin
          next_state = S_FIN;
        end else if (HostOwn) begin
          next_state = S_WAIT;
        end else begin
          next_state = S_STROBE;
        end
      end
      S_STROBE: begin
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (last_byte || Abort || abort_pend) begin
          next_state = S_FIN;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_FIN: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // FA/FD are separate from the running address so that they keep showing
  // the last byte written while the engine waits between windows.
  // abort_pend remembers an Abort seen during STROBE until HOLD exits.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      addr_cnt   <= '0;
      byte_idx   <= '0;
      fill_q     <= '0;
      pattern_q  <= 1'b0;
      abort_pend <= 1'b0;
      FA         <= '0;
      FD         <= '0;
      Remain     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (Start && (Len != '0)) begin
            addr_cnt  <= StartAddr;
            Remain    <= Len;
            fill_q    <= FillData;
            pattern_q <= Pattern;
            byte_idx  <= '0;
          end
        end
        S_WAIT: begin
          if (next_state == S_SETUP) begin
            FA <= addr_cnt;
            FD <= byte_val;
          end
        end
        S_STROBE: begin
          if (Abort) begin
            abort_pend <= 1'b1;
          end
        end
        S_HOLD: begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
          byte_idx <= byte_idx + LEN_W'(1);
          Remain   <= Remain - LEN_W'(1);
        end
        S_FIN: begin
          abort_pend <= 1'b0;
        end
        default: begin
          abort_pend <= 1'b0;
        end
      endcase
    end
  end

  // Pin controls decode straight from the state so that an asynchronous
  // reset releases the SRAM without waiting for a clock edge.
  always_comb begin
    Busy  = (state != S_IDLE);
    Done  = (state == S_FIN);
    FCS   = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    Owner = FCS;
    FWE   = (state == S_STROBE);
  end

endmodule
